// File: rtl/cs_frame_sf_buffer_pkg.sv
// cs_frame_sf_buffer_pkg
// Shared constants and helpers for the store-and-forward frame buffer:
//   PTR_EXTRA_BITS  - extra pointer bit that separates a full buffer from an empty one
//   PARITY_MAX_W    - widest payload the parity helper accepts (narrower words are zero-extended)
//   CNT_MAX         - saturation value of the 32-bit error counters
//   ptr_width()     - pointer width for a given buffer depth
//   even_parity_ok()- 1 when {parity, data} has even parity
//   sat_inc()       - saturating increment for the 32-bit counters
package cs_frame_sf_buffer_pkg;

    localparam int          PTR_EXTRA_BITS = 1;
    localparam int          PARITY_MAX_W   = 64;
    localparam logic [31:0] CNT_MAX        = 32'hFFFF_FFFF;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + PTR_EXTRA_BITS;
    endfunction

    // Zero-extending the payload leaves its parity unchanged.
    function automatic logic even_parity_ok(input logic p, input logic [PARITY_MAX_W-1:0] d);
        return ~(^{p, d});
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == CNT_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/cs_frame_sf_buffer_if.sv
// cs_frame_sf_buffer_if
// Byte-link bundle of the frame buffer.
//   upstream   : i_vld, i_last, i_parity, i_data in; o_rd (flow control) out
//   downstream : i_rd (pop) in; o_vld, o_last, o_data, o_frame_avail out
//   status     : o_parity_errors, o_dropped_frames out
// slave  = buffer side, master = the side that drives the link and pops words.
interface cs_frame_sf_buffer_if #(parameter int DATA_W = 8);

    logic              i_vld;
    logic              i_last;
    logic              i_parity;
    logic [DATA_W-1:0] i_data;
    logic              o_rd;
    logic              i_rd;
    logic              o_frame_avail;
    logic              o_vld;
    logic              o_last;
    logic [DATA_W-1:0] o_data;
    logic [31:0]       o_parity_errors;
    logic [31:0]       o_dropped_frames;

    modport slave (
        input  i_vld, i_last, i_parity, i_data, i_rd,
        output o_rd, o_frame_avail, o_vld, o_last, o_data, o_parity_errors, o_dropped_frames
    );

    modport master (
        output i_vld, i_last, i_parity, i_data, i_rd,
        input  o_rd, o_frame_avail, o_vld, o_last, o_data, o_parity_errors, o_dropped_frames
    );

endinterface

// File: rtl/cs_frame_sf_buffer_ram.sv
// cs_frame_sf_buffer_ram
// Simple dual-port single-clock RAM (sdp_ram_sync role), one registered read cycle.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read request, rdata valid the cycle after re
module cs_frame_sf_buffer_ram #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 2048
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset on the array or read register so the tools can map it to block RAM.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/cs_frame_sf_buffer.sv
// cs_frame_sf_buffer
// Store-and-forward frame buffer: only complete, clean frames become readable;
// frames with overflow, over-length or (optionally) parity errors are rewound.
//   i_sys_clk, i_sys_clk_srst : clock and synchronous active-high reset
//   bus (slave)               : upstream words, downstream FWFT words, error counters
module cs_frame_sf_buffer
    import cs_frame_sf_buffer_pkg::*;
#(
    parameter int DATA_W          = 8,
    parameter int DEPTH           = 2048,
    parameter int AFULL_MARGIN    = 16,
    parameter int MAX_FRAME_WORDS = 1518,
    parameter int DROP_ON_PARITY  = 1
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_clk_srst,
    cs_frame_sf_buffer_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_width(DEPTH);
    localparam int CW = $clog2(MAX_FRAME_WORDS + 1) + 1;

    logic              s1_vld, s1_last, s1_par;
    logic [DATA_W-1:0] s1_data;
    logic [PW-1:0]     wr_ptr, wr_commit, rd_ptr, frame_cnt, fill;
    logic              frame_bad;
    logic [CW-1:0]     word_cnt;
    logic              perr, perr_q, full, len_over, bad_now, commit;
    logic [31:0]       parity_errors, dropped_frames;
    logic              rd_ok;
    logic              ram_we, ram_re, ram_vld, avail, pop, pop_last;
    logic [DATA_W:0]   ram_q, pf0, pf1;
    logic [1:0]        pf_cnt;
    logic [2:0]        occ;

    // Frame verdict for the word in S1; bad_now folds in this word's own faults.
    // A prefetch read is issued only if it will still have a slot when it lands.
    always_comb begin
        fill     = wr_ptr - rd_ptr;
        full     = (fill == PW'(DEPTH));
        perr     = s1_vld && !even_parity_ok(s1_par, PARITY_MAX_W'(s1_data));
        len_over = (word_cnt >= CW'(MAX_FRAME_WORDS));
        bad_now  = frame_bad | full | len_over | (perr && (DROP_ON_PARITY != 0));
        ram_we   = s1_vld && !full;
        commit   = s1_vld && s1_last && !bad_now;
        pop      = bus.i_rd && (pf_cnt != 2'd0);
        pop_last = pop && pf0[DATA_W];
        avail    = (rd_ptr != wr_commit);
        occ      = {1'b0, pf_cnt} + {2'b00, ram_vld} - {2'b00, pop};
        ram_re   = avail && (occ <= 3'd1);
    end

    // Input register and speculative write side; a bad frame rewinds to wr_commit.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_clk_srst) begin
            s1_vld         <= 1'b0;
            s1_last        <= 1'b0;
            s1_par         <= 1'b0;
            s1_data        <= '0;
            wr_ptr         <= '0;
            wr_commit      <= '0;
            frame_bad      <= 1'b0;
            word_cnt       <= '0;
            dropped_frames <= '0;
        end else begin
            s1_vld  <= bus.i_vld;
            s1_last <= bus.i_last;
            s1_par  <= bus.i_parity;
            s1_data <= bus.i_data;
            if (s1_vld) begin
                if (s1_last) begin
                    frame_bad <= 1'b0;
                    word_cnt  <= '0;
                    if (bad_now) begin
                        wr_ptr         <= wr_commit;
                        dropped_frames <= sat_inc(dropped_frames);
                    end else begin
                        wr_ptr    <= wr_ptr + 1'b1;
                        wr_commit <= wr_ptr + 1'b1;
                    end
                end else begin
                    frame_bad <= bad_now;
                    if (!len_over)
                        word_cnt <= word_cnt + 1'b1;
                    if (!full)
                        wr_ptr <= wr_ptr + 1'b1;
                end
            end
        end
    end

    // Parity errors are counted one stage behind S1.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_clk_srst) begin
            perr_q        <= 1'b0;
            parity_errors <= '0;
        end else begin
            perr_q <= perr;
            if (perr_q)
                parity_errors <= sat_inc(parity_errors);
        end
    end

    // Read pointer, two-entry FWFT prefetch (pf0 is the head), frame count, flow control.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_clk_srst) begin
            rd_ptr    <= '0;
            ram_vld   <= 1'b0;
            pf_cnt    <= 2'd0;
            pf0       <= '0;
            pf1       <= '0;
            frame_cnt <= '0;
            rd_ok     <= 1'b1;
        end else begin
            ram_vld <= ram_re;
            if (ram_re)
                rd_ptr <= rd_ptr + 1'b1;
            if (ram_vld && pop) begin
                if (pf_cnt == 2'd1) begin
                    pf0 <= ram_q;
                end else begin
                    pf0 <= pf1;
                    pf1 <= ram_q;
                end
            end else if (pop) begin
                pf0    <= pf1;
                pf_cnt <= pf_cnt - 2'd1;
            end else if (ram_vld) begin
                if (pf_cnt == 2'd0)
                    pf0 <= ram_q;
                else
                    pf1 <= ram_q;
                pf_cnt <= pf_cnt + 2'd1;
            end
            case ({commit, pop_last})
                2'b10:   frame_cnt <= frame_cnt + 1'b1;
                2'b01:   frame_cnt <= frame_cnt - 1'b1;
                default: frame_cnt <= frame_cnt;
            endcase
            rd_ok <= ~(fill >= PW'(DEPTH - AFULL_MARGIN));
        end
    end

    cs_frame_sf_buffer_ram #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (i_sys_clk),
        .we    (ram_we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata ({s1_last, s1_data}),
        .re    (ram_re),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (ram_q)
    );

    assign bus.o_rd             = rd_ok;
    assign bus.o_vld            = (pf_cnt != 2'd0);
    assign bus.o_last           = bus.o_vld & pf0[DATA_W];
    assign bus.o_data           = bus.o_vld ? pf0[DATA_W-1:0] : '0;
    assign bus.o_frame_avail    = (frame_cnt != '0);
    assign bus.o_parity_errors  = parity_errors;
    assign bus.o_dropped_frames = dropped_frames;

endmodule
